// File: rtl/duft_pkg.sv
// duft_pkg: shared types and constants for the ap_ctrl_chain command master.
//   state_t   : sequencer states (IDLE/ISSUE/WAIT/ERR)
//   cmd_t     : one buffered command {addr, wr_data, rd_wr}
//   ADDR_IDLE : address driven to the DUFT while nothing has been issued
//   RD / WR   : encodings of the rd_wr bit
package duft_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    ERR
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        rd_wr;
  } cmd_t;

  localparam int unsigned CMD_W     = $bits(cmd_t);
  localparam logic [31:0] ADDR_IDLE = 32'hFFFF_FFFF;
  localparam logic        RD        = 1'b1;
  localparam logic        WR        = 1'b0;

endpackage

// File: rtl/duft_cmd_fifo.sv
// duft_cmd_fifo: synchronous command FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write request; accepted only while ready is high
//   push_data  : entry to store
//   ready      : registered "not full"; low during reset
//   pop        : remove head entry (ignored when empty)
//   head       : current head entry (valid when !empty)
//   empty      : FIFO holds no entries
module duft_cmd_fifo #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             ready,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  // One extra pointer bit separates full from empty when the indices wrap.
  logic [AW:0]      wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop, full_d;

  assign do_push  = push && ready;
  assign do_pop   = pop && !empty;
  assign empty    = (wr_ptr == rd_ptr);
  assign head     = mem[rd_ptr[AW-1:0]];
  assign wr_ptr_d = wr_ptr + (AW+1)'(do_push);
  assign rd_ptr_d = rd_ptr + (AW+1)'(do_pop);
  assign full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                    (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);

  // ready comes from the registered next-full state, so a push can never
  // land on a full FIFO even when a pop happens in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ready  <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_d;
      rd_ptr <= rd_ptr_d;
      ready  <= !full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/duft_chain_master.sv
// duft_chain_master: upstream command sequencer for an ap_ctrl_chain DUFT.
//   ap_clk, ap_rst_n        : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     : command stream in (cmd_addr, cmd_wr_data, cmd_rd_wr 1=read)
//   rsp_valid/rsp_ready     : response stream out (rsp_data, rsp_is_rd, rsp_err)
//   addr, wr_data, rd_wr    : command presented to the DUFT, stable while ap_start
//   ap_start, ap_continue   : request / result-consumed strobe to the DUFT
//   ap_ce                   : DUFT clock enable, dropped for one cycle on timeout
//   ap_ready, ap_done       : DUFT accepted inputs / result valid
//   ap_idle                 : DUFT status, not used for control
//   ap_return               : DUFT read data
//   busy                    : commands queued or a transaction in flight
module duft_chain_master
  import duft_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 256
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wr_data,
  input  logic        cmd_rd_wr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_is_rd,
  output logic        rsp_err,
  output logic [31:0] addr,
  output logic [31:0] wr_data,
  output logic        rd_wr,
  output logic        ap_start,
  output logic        ap_continue,
  output logic        ap_ce,
  input  logic        ap_ready,
  input  logic        ap_done,
  input  logic        ap_idle,
  input  logic [31:0] ap_return,
  output logic        busy
);

  localparam int unsigned     TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT);

  state_t          state, state_d;
  logic            err_phase;
  logic [TO_W-1:0] to_cnt;
  cmd_t            head, push_cmd;
  logic            fifo_empty, pop;
  logic            rsp_free, done_now, timed_out, cap, cap_err;
  logic            unused_ok;

  assign unused_ok = ap_idle;
  assign push_cmd  = '{addr: cmd_addr, wr_data: cmd_wr_data, rd_wr: cmd_rd_wr};

  duft_cmd_fifo #(
    .WIDTH(CMD_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (ap_clk),
    .rst_n    (ap_rst_n),
    .push     (cmd_valid),
    .push_data(push_cmd),
    .ready    (cmd_ready),
    .pop      (pop),
    .head     (head),
    .empty    (fifo_empty)
  );

  // The response slot can take a new entry if empty or drained this cycle.
  assign rsp_free  = !rsp_valid || rsp_ready;
  assign done_now  = ((state == ISSUE) && ap_ready && ap_done) ||
                     ((state == WAIT) && ap_done);
  // Fires on the cycle the counter would reach TIMEOUT; if the response slot
  // is occupied the counter saturates and the timeout waits for space.
  assign timed_out = ((state == ISSUE) || (state == WAIT)) && (to_cnt >= TO_LAST);

  assign ap_start = (state == ISSUE);
  assign ap_ce    = !((state == ERR) && !err_phase);
  assign busy     = !fifo_empty || (state != IDLE);

  always_comb begin
    state_d     = state;
    pop         = 1'b0;
    ap_continue = 1'b0;
    cap         = 1'b0;
    cap_err     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE, WAIT: begin
        if (done_now && rsp_free) begin
          cap         = 1'b1;
          ap_continue = 1'b1;
          state_d     = IDLE;
        end else if (timed_out && rsp_free) begin
          cap     = 1'b1;
          cap_err = 1'b1;
          state_d = ERR;
        end else if ((state == ISSUE) && ap_ready) begin
          state_d = WAIT;
        end
      end
      ERR: begin
        // First ERR cycle gates the DUFT clock, second releases it and
        // flushes the aborted transaction with ap_continue.
        if (err_phase) begin
          ap_continue = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= IDLE;
      err_phase <= 1'b0;
      to_cnt    <= '0;
      addr      <= ADDR_IDLE;
      wr_data   <= '0;
      rd_wr     <= WR;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_is_rd <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_d;
      err_phase <= (state == ERR) && !err_phase;

      if (pop) begin
        addr    <= head.addr;
        wr_data <= head.wr_data;
        rd_wr   <= head.rd_wr;
        to_cnt  <= '0;
      end else if (((state == ISSUE) || (state == WAIT)) && (to_cnt != TO_MAX)) begin
        to_cnt <= to_cnt + TO_W'(1);
      end

      if (cap) begin
        rsp_valid <= 1'b1;
        rsp_data  <= (!cap_err && (rd_wr == RD)) ? ap_return : '0;
        rsp_is_rd <= rd_wr;
        rsp_err   <= cap_err;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_duft_chain_master.sv
// tb_duft_chain_master: directed self-checking bench for duft_chain_master
// (FIFO_DEPTH=4, TIMEOUT=16) with a small behavioural DUFT responder.
module tb_duft_chain_master;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wr_data = '0;
  logic        cmd_rd_wr = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_is_rd;
  logic        rsp_err;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic        rd_wr;
  logic        ap_start;
  logic        ap_continue;
  logic        ap_ce;
  logic        ap_ready = 1'b0;
  logic        ap_done = 1'b0;
  logic        ap_idle = 1'b1;
  logic [31:0] ap_return = '0;
  logic        busy;

  always #5 ap_clk = ~ap_clk;

  duft_chain_master #(
    .FIFO_DEPTH(4),
    .TIMEOUT   (16)
  ) dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_wr_data(cmd_wr_data),
    .cmd_rd_wr  (cmd_rd_wr),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_is_rd  (rsp_is_rd),
    .rsp_err    (rsp_err),
    .addr       (addr),
    .wr_data    (wr_data),
    .rd_wr      (rd_wr),
    .ap_start   (ap_start),
    .ap_continue(ap_continue),
    .ap_ce      (ap_ce),
    .ap_ready   (ap_ready),
    .ap_done    (ap_done),
    .ap_idle    (ap_idle),
    .ap_return  (ap_return),
    .busy       (busy)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // ---------------- DUFT responder ----------------
  int unsigned rdy_lat = 1;
  int unsigned done_lat = 1;
  bit          stall = 1'b0;
  bit          hang = 1'b0;
  bit          combo = 1'b0;
  bit          pending = 1'b0;
  bit          combo_now = 1'b0;
  int unsigned start_cnt = 0;
  int unsigned wait_cnt = 0;
  logic [31:0] lat_addr = '0;
  logic        lat_rd = 1'b0;

  function automatic logic [31:0] duft_val(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEAD_BEEF : a + 32'h1000_0000;
  endfunction

  initial begin : duft_model
    logic        s_start, s_ready, s_done, s_cont, s_rd;
    logic [31:0] s_addr;
    forever begin
      @(negedge ap_clk);
      s_start = ap_start;
      s_ready = ap_ready;
      s_done  = ap_done;
      s_cont  = ap_continue;
      s_rd    = rd_wr;
      s_addr  = addr;
      @(posedge ap_clk);
      #1;
      if (!ap_rst_n) begin
        ap_ready  = 1'b0;
        ap_done   = 1'b0;
        ap_return = '0;
        pending   = 1'b0;
        combo_now = 1'b0;
        start_cnt = 0;
        wait_cnt  = 0;
      end else begin
        if (s_done && s_cont) ap_done = 1'b0;
        if (s_cont && pending) pending = 1'b0;
        if (s_start && s_ready) begin
          ap_ready  = 1'b0;
          start_cnt = 0;
          if (!combo_now) begin
            pending  = 1'b1;
            wait_cnt = 0;
            lat_addr = s_addr;
            lat_rd   = s_rd;
          end
          combo_now = 1'b0;
        end else if (s_start && !s_ready && !stall) begin
          if (start_cnt >= rdy_lat) begin
            ap_ready  = 1'b1;
            start_cnt = 0;
            if (combo && s_rd) begin
              ap_done   = 1'b1;
              ap_return = duft_val(s_addr);
              combo_now = 1'b1;
            end
          end else begin
            start_cnt++;
          end
        end
        if (pending && !hang) begin
          if (wait_cnt >= done_lat) begin
            ap_done   = 1'b1;
            ap_return = lat_rd ? duft_val(lat_addr) : 32'h5555_5555;
            pending   = 1'b0;
          end else begin
            wait_cnt++;
          end
        end
      end
    end
  end

  // ---------------- monitor ----------------
  typedef struct {
    logic [31:0] data;
    logic        is_rd;
    logic        err;
    int unsigned cyc;
  } rsp_t;

  rsp_t        rsp_q[$];
  int unsigned cyc = 0;
  int unsigned start_cyc = 0;
  int unsigned start_high = 0;
  int unsigned cont_cnt = 0;
  int unsigned ce_low = 0;
  logic        prev_start = 1'b0;

  initial begin : monitor
    rsp_t r;
    forever begin
      @(negedge ap_clk);
      if (ap_rst_n) begin
        cyc++;
        if (ap_start && !prev_start) start_cyc = cyc;
        prev_start = ap_start;
        if (ap_start) start_high++;
        if (ap_continue) cont_cnt++;
        if (!ap_ce) ce_low++;
        if (rsp_valid && rsp_ready) begin
          r.data  = rsp_data;
          r.is_rd = rsp_is_rd;
          r.err   = rsp_err;
          r.cyc   = cyc;
          rsp_q.push_back(r);
        end
      end else begin
        prev_start = 1'b0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic sync();
    @(posedge ap_clk);
    #1;
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic push_cmd(input logic rd, input logic [31:0] a, input logic [31:0] d);
    int unsigned n = 0;
    cmd_valid   = 1'b1;
    cmd_rd_wr   = rd;
    cmd_addr    = a;
    cmd_wr_data = d;
    @(negedge ap_clk);
    while (!cmd_ready && n < 200) begin
      @(negedge ap_clk);
      n++;
    end
    if (n >= 200) check("push_accept", 32'(cmd_ready), 32'd1);
    @(posedge ap_clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsps(input int unsigned n, input string tag);
    int unsigned k = 0;
    while (rsp_q.size() < n && k < 300) begin
      @(negedge ap_clk);
      k++;
    end
    check({tag, "_count"}, 32'(rsp_q.size()), 32'(n));
    sync();
  endtask

  task automatic expect_rsp(input string tag, input logic [31:0] d, input logic rd, input logic er);
    rsp_t r;
    if (rsp_q.size() == 0) begin
      check({tag, "_present"}, 32'(rsp_q.size()), 32'd1);
    end else begin
      r = rsp_q.pop_front();
      check({tag, "_data"}, r.data, d);
      check({tag, "_is_rd"}, 32'(r.is_rd), 32'(rd));
      check({tag, "_err"}, 32'(r.err), 32'(er));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int unsigned c0, s0, k0, bad;
    int unsigned n;

    // Reset values
    @(negedge ap_clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_addr", addr, 32'hFFFF_FFFF);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_ap_start", 32'(ap_start), 32'd0);
    check("rst_ap_cont", 32'(ap_continue), 32'd0);
    check("rst_ap_ce", 32'(ap_ce), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    #2 ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check("rel_cmd_ready", 32'(cmd_ready), 32'd1);
    sync();

    // 1: single read, ready and done together
    combo = 1'b1; rdy_lat = 1;
    c0 = cont_cnt;
    push_cmd(1'b1, 32'h10, 32'h0);
    wait_rsps(1, "t1");
    expect_rsp("t1", 32'hDEAD_BEEF, 1'b1, 1'b0);
    check("t1_cont_pulses", 32'(cont_cnt - c0), 32'd1);

    // 2: single write, ap_start held through a slow ap_ready
    combo = 1'b0; rdy_lat = 3; done_lat = 2;
    s0 = start_high;
    push_cmd(1'b0, 32'h20, 32'h1234);
    n = 0;
    while (!ap_start && n < 20) begin
      @(negedge ap_clk);
      n++;
    end
    check("t2_addr", addr, 32'h20);
    check("t2_wr_data", wr_data, 32'h1234);
    check("t2_rd_wr", 32'(rd_wr), 32'd0);
    wait_rsps(1, "t2");
    expect_rsp("t2", 32'h0, 1'b0, 1'b0);
    check("t2_start_cycles", 32'(start_high - s0), 32'd5);

    // 3: five commands into a depth-4 FIFO with the DUFT stalled
    stall = 1'b1; rdy_lat = 1; done_lat = 2;
    c0 = cont_cnt;
    push_cmd(1'b1, 32'h100, 32'h0);
    push_cmd(1'b0, 32'h104, 32'h1);
    push_cmd(1'b1, 32'h108, 32'h0);
    push_cmd(1'b0, 32'h10C, 32'h2);
    push_cmd(1'b1, 32'h110, 32'h0);
    @(negedge ap_clk);
    check("t3_full_ready", 32'(cmd_ready), 32'd0);
    check("t3_stalled_start", 32'(ap_start), 32'd1);
    check("t3_stalled_addr", addr, 32'h100);
    sync();
    stall = 1'b0;
    wait_rsps(5, "t3");
    expect_rsp("t3_0", 32'h1000_0100, 1'b1, 1'b0);
    expect_rsp("t3_1", 32'h0, 1'b0, 1'b0);
    expect_rsp("t3_2", 32'h1000_0108, 1'b1, 1'b0);
    expect_rsp("t3_3", 32'h0, 1'b0, 1'b0);
    expect_rsp("t3_4", 32'h1000_0110, 1'b1, 1'b0);
    check("t3_cont_pulses", 32'(cont_cnt - c0), 32'd5);

    // 4: response back-pressure across two reads
    rsp_ready = 1'b0; done_lat = 1;
    push_cmd(1'b1, 32'h200, 32'h0);
    push_cmd(1'b1, 32'h204, 32'h0);
    n = 0;
    while (!rsp_valid && n < 60) begin
      @(negedge ap_clk);
      n++;
    end
    check("t4_first_valid", 32'(rsp_valid), 32'd1);
    c0 = cont_cnt;
    bad = 0;
    repeat (20) begin
      @(negedge ap_clk);
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h1000_0200 || rsp_is_rd !== 1'b1 || rsp_err !== 1'b0)
        bad++;
    end
    check("t4_hold_stable", 32'(bad), 32'd0);
    check("t4_cont_withheld", 32'(cont_cnt - c0), 32'd0);
    check("t4_busy_held", 32'(busy), 32'd1);
    sync();
    rsp_ready = 1'b1;
    wait_rsps(2, "t4");
    expect_rsp("t4_0", 32'h1000_0200, 1'b1, 1'b0);
    expect_rsp("t4_1", 32'h1000_0204, 1'b1, 1'b0);
    check("t4_cont_after", 32'(cont_cnt - c0), 32'd1);

    // 5: DUFT never finishes -> timeout error, then recovery
    hang = 1'b1;
    c0 = cont_cnt; k0 = ce_low;
    push_cmd(1'b1, 32'h300, 32'h0);
    wait_rsps(1, "t5");
    if (rsp_q.size() != 0)
      check("t5_err_latency", 32'(rsp_q[0].cyc - start_cyc), 32'd16);
    expect_rsp("t5", 32'h0, 1'b1, 1'b1);
    repeat (3) @(negedge ap_clk);
    check("t5_ce_low_cycles", 32'(ce_low - k0), 32'd1);
    check("t5_cont_pulses", 32'(cont_cnt - c0), 32'd1);
    check("t5_idle", 32'(busy), 32'd0);
    sync();
    hang = 1'b0;
    push_cmd(1'b1, 32'h304, 32'h0);
    wait_rsps(1, "t5b");
    expect_rsp("t5b", 32'h1000_0304, 1'b1, 1'b0);

    // 6: asynchronous reset while waiting for ap_done
    hang = 1'b1;
    push_cmd(1'b1, 32'h400, 32'h0);
    n = 0;
    while (!ap_start && n < 50) begin
      @(negedge ap_clk);
      n++;
    end
    n = 0;
    while (ap_start && n < 50) begin
      @(negedge ap_clk);
      n++;
    end
    check("t6_in_wait", 32'({busy, ap_start}), 32'b10);
    #2 ap_rst_n = 1'b0;
    #1;
    check("t6_ap_start", 32'(ap_start), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_addr", addr, 32'hFFFF_FFFF);
    check("t6_cmd_ready", 32'(cmd_ready), 32'd0);
    check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t6_ap_ce", 32'(ap_ce), 32'd1);
    repeat (3) @(negedge ap_clk);
    hang = 1'b0; combo = 1'b1;
    #2 ap_rst_n = 1'b1;
    repeat (8) @(negedge ap_clk);
    check("t6_no_stale_rsp", 32'(rsp_q.size()), 32'd0);
    check("t6_rsp_valid_after", 32'(rsp_valid), 32'd0);
    check("t6_ready_after", 32'(cmd_ready), 32'd1);
    sync();
    push_cmd(1'b1, 32'h10, 32'h0);
    wait_rsps(1, "t6b");
    expect_rsp("t6b", 32'hDEAD_BEEF, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
